mem_stage: RTL
==============

# mem_stage

Memory-access stage of the RISC-V pipeline, directly downstream of the ALU. It turns the ALU result into a data-memory address, aligns store data, and generates byte-enables in the EX cycle. It then registers the instruction into the M stage, where it extracts and extends synchronous-read load data and selects the writeback value. That writeback value also feeds the forwarding path back to the ALU operands.

## Interface
Parameters:
- AWIDTH, 14, word-address width of data memory (16K words)
- DMEM_TAG, 4'b0001, value of address bits [31:28] that selects data memory

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- ex_valid  in  1  EX-stage instruction is real (not a bubble)
- ex_alu_out  in  32  ALU result; effective address for loads/stores
- ex_rs2  in  32  store data (forwarded rs2)
- ex_pc4  in  32  PC+4 of the EX instruction
- ex_rd  in  5  destination register
- ex_reg_wen  in  1  instruction writes rd
- ex_mem_rd, ex_mem_wr  in  1 each  load / store
- ex_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 ALU
- stall  in  1  hold the M register; no new memory access
- flush  in  1  kill the EX instruction
- dmem_en  out  1  memory enable
- dmem_we  out  4  byte write enables
- dmem_addr  out  AWIDTH  word address
- dmem_din  out  32  lane-replicated store data
- dmem_dout  in  32  read data, valid the cycle after dmem_en; held while dmem_en=0
- wb_valid, wb_wen  out  1 each  M-stage instruction valid / writes rd
- wb_rd  out  5;  wb_data  out  32  writeback/forwarding value
- misalign  out  1  M-stage instruction was a misaligned access

## Operation
- **Decode:** hit = ex_alu_out[31:28]==DMEM_TAG. off = ex_alu_out[1:0].
- **Misalignment:** mis = (H/HU/SH and off[0]) or (W/SW and off≠0).
- **Go condition:** go = ex_valid & !stall & !flush.
- **Memory drive (combinational, EX cycle):**
  - dmem_addr = ex_alu_out[AWIDTH+1:2].
  - dmem_en = go & hit & (ex_mem_rd | ex_mem_wr) & !mis.
- **Store lanes:**
  - SB: din = {4{rs2[7:0]}}, we = 4'b0001<<off.
  - SH: din = {2{rs2[15:0]}}, we = 4'b0011<<off.
  - SW: din = rs2, we = 4'b1111.
  - dmem_we = 0 unless dmem_en & ex_mem_wr.
- **M register update, each clock:**
  - rst=0: clear all fields.
  - Else flush=1: load a bubble (valid=0). Flush wins over stall.
  - Else stall=1: hold.
  - Else capture {valid, rd, reg_wen&!(mis&(mem_rd|mem_wr)), mem_rd, hit, funct3, off, wb_sel, alu_out, pc4, mis&(mem_rd|mem_wr)}.
- **Load extraction (M cycle):**
  - Pick the byte or halfword at m_off from dmem_dout.
  - Sign-extend for B/H; zero-extend for BU/HU; W passes through.
  - A load with m_hit=0 returns 0.
- **Writeback outputs:**
  - wb_data is selected by m_wb_sel from m_alu, the load result, or m_pc4.
  - wb_valid = m_valid; wb_wen = m_valid & m_reg_wen; wb_rd = m_rd; misalign = m_valid & m_mis.
- **Memory hold requirement:** data memory holds dmem_dout while dmem_en=0. This makes a stalled load's data stable in M.

## Timing
- Reset (rst=0 at a clock edge) gives wb_valid=0, wb_wen=0, wb_rd=0, wb_data=0, misalign=0.
- dmem_* outputs are combinational from the ex_* inputs, so they are 0/inactive whenever ex_valid=0.
- Store: the write commits at the edge ending the EX cycle. The store reaches M on that same edge with wb_wen=0.
- Load: address is presented in cycle N; wb_data is valid in cycle N+1 (1-cycle latency). No load-use forwarding exists inside the block; the hazard unit stalls.
- Non-memory instructions: wb_data = registered ALU/PC+4 value in cycle N+1.
- Stall: M outputs are unchanged for every stalled cycle and no memory access is issued. The instruction held in EX re-presents when stall drops.
- Flush coincident with a store: the write is suppressed; next cycle wb_valid=0.
- Reset mid-load: the load is discarded and outputs follow the reset values on the next cycle. A store presented in the reset cycle is still gated only by go, so the hazard unit holds ex_valid=0 during reset.

## Test plan
- **SW then LW, same word:** SW 0x1000_0010 with rs2=0xDEADBEEF gives we=1111, addr=4. LW from 0x1000_0010 gives wb_data=0xDEADBEEF, wb_wen=1 one cycle later.
- **Byte and half lanes:** SB 0x80 at off=3 gives we=1000, din=0x80808080. LB at off=3 gives 0xFFFFFF80; LBU gives 0x00000080. LHU at off=2 of 0x8001_1234 gives 0x00008001.
- **Misaligned accesses:** LW at off=2 gives misalign=1, wb_wen=0. SH at off=1 gives dmem_en=0, we=0000.
- **Stall during load:** stall held 3 cycles after a load gives wb_data stable at the loaded value, with dmem_en=0 throughout.
- **Flush during a store, and stall+flush:** flush with a store in EX gives we=0000 and wb_valid=0 next cycle. stall=1 together with flush=1 gives a bubble, not a hold.
- **Reset:** rst=0 mid-sequence gives all wb outputs 0 next cycle. JAL with wb_sel=10, pc4=0x104 gives wb_data=0x104.

Source files
------------

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage: memory-access stage of the RISC-V pipeline.
//   EX cycle : decodes the ALU result into a data-memory word address,
//              lane-replicates store data, builds byte enables and drives the
//              synchronous data memory combinationally.
//   M cycle  : registered copy of the instruction; extracts/extends the load
//              data returned by memory and selects the writeback value, which
//              also serves as the forwarding value to the ALU.
// Ports:
//   clk, rst (synchronous, active-low)
//   ex_*      : EX-stage instruction fields (valid, alu_out, rs2, pc4, rd,
//               reg_wen, mem_rd, mem_wr, funct3, wb_sel)
//   stall     : hold the M register, issue no memory access
//   flush     : kill the EX instruction (wins over stall)
//   dmem_*    : data memory enable, byte write enables, word address,
//               write data, read data (valid the cycle after dmem_en)
//   wb_*      : M-stage valid / write enable / rd / writeback data
//   misalign  : M-stage instruction was a misaligned memory access
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned AWIDTH   = 14,
    parameter logic [3:0]  DMEM_TAG = 4'b0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       ex_alu_out,
    input  logic [31:0]       ex_rs2,
    input  logic [31:0]       ex_pc4,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_wen,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [2:0]        ex_funct3,
    input  logic [1:0]        ex_wb_sel,
    input  logic              stall,
    input  logic              flush,
    output logic              dmem_en,
    output logic [3:0]        dmem_we,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [31:0]       dmem_din,
    input  logic [31:0]       dmem_dout,
    output logic              wb_valid,
    output logic              wb_wen,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign
);

    // M-stage pipeline register payload
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_wen;
        logic        mem_rd;
        logic        hit;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [1:0]  wb_sel;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        mis;
    } m_reg_t;

    m_reg_t      m_q;
    m_reg_t      m_next;

    logic        hit;
    logic [1:0]  off;
    logic        go;
    logic        access;
    logic        mis;
    logic        mis_acc;
    logic [3:0]  we_raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    // EX-cycle decode
    assign hit     = (ex_alu_out[31:28] == DMEM_TAG);
    assign off     = ex_alu_out[1:0];
    assign go      = ex_valid && !stall && !flush;
    assign access  = ex_mem_rd || ex_mem_wr;
    assign mis_acc = mis && access;

    // Alignment check on the access size encoded in funct3
    always_comb begin
        mis = 1'b0;
        case (ex_funct3)
            3'b001, 3'b101: mis = off[0];
            3'b010:         mis = (off != 2'b00);
            default:        mis = 1'b0;
        endcase
    end

    // Store data is replicated across lanes; byte enables pick the lanes
    always_comb begin
        we_raw   = 4'b1111;
        dmem_din = ex_rs2;
        case (ex_funct3[1:0])
            2'b00: begin
                we_raw   = 4'(4'b0001 << off);
                dmem_din = {4{ex_rs2[7:0]}};
            end
            2'b01: begin
                we_raw   = 4'(4'b0011 << off);
                dmem_din = {2{ex_rs2[15:0]}};
            end
            default: begin
                we_raw   = 4'b1111;
                dmem_din = ex_rs2;
            end
        endcase
    end

    assign dmem_addr = ex_alu_out[AWIDTH+1:2];
    assign dmem_en   = go && hit && access && !mis;
    assign dmem_we   = (dmem_en && ex_mem_wr) ? we_raw : 4'b0000;

    // Next M-register contents; misaligned accesses never write rd
    always_comb begin
        m_next         = '0;
        m_next.valid   = ex_valid;
        m_next.rd      = ex_rd;
        m_next.reg_wen = ex_reg_wen && !mis_acc;
        m_next.mem_rd  = ex_mem_rd;
        m_next.hit     = hit;
        m_next.funct3  = ex_funct3;
        m_next.off     = off;
        m_next.wb_sel  = ex_wb_sel;
        m_next.alu     = ex_alu_out;
        m_next.pc4     = ex_pc4;
        m_next.mis     = mis_acc;
    end

    // M register: reset, then flush (bubble), then stall (hold)
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_q <= '0;
        end else if (flush) begin
            m_q <= '0;
        end else if (!stall) begin
            m_q <= m_next;
        end
    end

    // Load extraction from the word returned by memory
    always_comb begin
        byte_sel = 8'h00;
        half_sel = m_q.off[1] ? dmem_dout[31:16] : dmem_dout[15:0];
        load_val = dmem_dout;
        case (m_q.off)
            2'b00:   byte_sel = dmem_dout[7:0];
            2'b01:   byte_sel = dmem_dout[15:8];
            2'b10:   byte_sel = dmem_dout[23:16];
            default: byte_sel = dmem_dout[31:24];
        endcase
        case (m_q.funct3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h000000, byte_sel};
            3'b101:  load_val = {16'h0000, half_sel};
            default: load_val = dmem_dout;
        endcase
        // Loads outside the data-memory region read as zero
        if (!(m_q.mem_rd && m_q.hit)) begin
            load_val = 32'h0000_0000;
        end
    end

    // Writeback / forwarding value
    always_comb begin
        wb_data = m_q.alu;
        case (m_q.wb_sel)
            2'b01:   wb_data = load_val;
            2'b10:   wb_data = m_q.pc4;
            default: wb_data = m_q.alu;
        endcase
    end

    assign wb_valid = m_q.valid;
    assign wb_wen   = m_q.valid && m_q.reg_wen;
    assign wb_rd    = m_q.rd;
    assign misalign = m_q.valid && m_q.mis;

endmodule
